xpb_table_gen: RTL and testbench
================================

# xpb_table_gen

Sequential generator that writes an xpb reduction lookup table: for index j = 0..2^IDX_BITS-1 it produces (j · base) mod modulus and writes it through a handshaked write port into table RAM. It is the runtime writer for the xpb lookup path in the modular squaring datapath. The squarer's xpb readers currently use constant tables fixed at synthesis; this block lets the table contents follow a modulus and segment base supplied after configuration.

## Interface
- WIDTH, 1024, bit width of modulus, base and table entries
- IDX_BITS, 5, table index width; table depth is 2^IDX_BITS

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- modulus  in  WIDTH  modulus N, sampled when start is accepted
- base  in  WIDTH  segment base B (2^k mod N), sampled when start is accepted; must satisfy B < N
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the table is complete or aborted
- err  out  1  one-cycle pulse, coincident with done, when B >= N (includes N = 0)
- wr_en  out  1  write request valid
- wr_ready  in  1  sink accepts the write; a transfer occurs when wr_en && wr_ready
- wr_addr  out  IDX_BITS  table index j
- wr_data  out  WIDTH  (j · B) mod N

## Operation
- States: IDLE, CHECK, EMIT, ADD, REDUCE, DONE.
- IDLE: on start, register N and B, clear acc (WIDTH) and idx (IDX_BITS), go to CHECK. While not in IDLE, start is ignored.
- CHECK: if B >= N, set err and go to DONE with no writes. Otherwise go to EMIT.
- EMIT: drive wr_en=1, wr_addr=idx, wr_data=acc; hold all three stable until wr_ready.
  - On transfer with idx = max: go to DONE.
  - On transfer otherwise: go to ADD.
- ADD: sum (WIDTH+1 bits) = acc + B; go to REDUCE.
- REDUCE: acc = (sum >= N) ? sum − N : sum; idx = idx + 1; go to EMIT. One conditional subtraction suffices because acc < N and B < N.
- DONE: done=1 and err as determined in CHECK; go to IDLE.
- Entry 0 is always 0. Arithmetic is unsigned. The sum carry bit takes part in the compare.
- Reset, including mid-table: next state IDLE; busy, done, err, wr_en = 0; acc, idx, wr_addr, wr_data = 0. Writes already transferred are not undone. No write is issued after reset.

## Timing
- All outputs are registered. Reset values are all zero.
- Start accepted at cycle 0: CHECK at cycle 1, first wr_en at cycle 2.
- With wr_ready held high, entry j is presented at cycle 2 + 3j. For depth 32, the last entry is at cycle 95, done at cycle 96, IDLE at cycle 97.
- Each cycle of wr_ready low in EMIT adds one cycle. wr_en never drops without a transfer.
- Error path: err and done both pulse at cycle 2; busy high for cycles 1–2.
- A new start is accepted in the cycle after DONE (IDLE).

## Structure
- Package xpb_pkg holds:
  - default WIDTH (1024) and IDX_BITS (5);
  - the state enum xpb_gen_state_t;
  - the depth constant XPB_DEPTH = 2^IDX_BITS.
- One sub-module, xpb_mod_step: registered add followed by compare/conditional-subtract (ADD/REDUCE datapath), WIDTH-parameterised. It is reusable by later modular-accumulate blocks.
- Control FSM, index counter and write port stay in xpb_table_gen.

## Test plan
- WIDTH=16, N=0xFFF1, B=0x1234, wr_ready=1:
  - 32 writes at cycles 2, 5, …, 95;
  - addr 1 = 0x1234, addr 31 = 0x346A;
  - done at cycle 96, err=0;
  - every entry matches the (j·B) mod N golden model.
- Wrap case, N=0xFFF1, B=0xFFF0 (N−1): addr j = N−j, so addr 1 = 0xFFF0, addr 2 = 0xFFEF, addr 31 = 0xFFD2. This exercises the sum-carry path.
- Error cases:
  - B = N = 0xFFF1: err and done at cycle 2, no wr_en ever.
  - N = 0: same response.
- Backpressure: hold wr_ready=0 for 5 cycles while addr 3 is presented. wr_addr=3 and wr_data=0x369C stay stable; all later entries shift by 5 cycles; done at cycle 101.
- Reset and ignored start:
  - Assert reset while addr 10 is in EMIT: wr_en, busy, done = 0 next cycle, no further writes. A fresh start then regenerates the table from addr 0.
  - A start pulse during busy is ignored.
- Full width: WIDTH=1024, IDX_BITS=5 with the production modulus and segment base. All 32 entries match the constant xpb ROM contents for that segment bit for bit.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared constants and state encoding for the xpb lookup-table writer.
package xpb_pkg;

  localparam int XPB_WIDTH    = 1024;
  localparam int XPB_IDX_BITS = 5;
  localparam int XPB_DEPTH    = 2 ** XPB_IDX_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EMIT,
    ST_ADD,
    ST_REDUCE,
    ST_DONE
  } xpb_gen_state_t;

endpackage

// File: rtl/xpb_mod_step.sv
// Modular accumulate step: registered acc + addend, then one conditional
// subtraction of the modulus. Valid while acc < modulus and addend < modulus.
module xpb_mod_step
  import xpb_pkg::*;
#(
  parameter int WIDTH = XPB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic             reduce_en,
  input  logic [WIDTH-1:0] addend,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] acc
);

  // The carry bit is kept so a sum past 2^WIDTH still compares against N.
  logic [WIDTH:0] sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sum <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (reduce_en) begin
        acc <= (sum >= {1'b0, modulus}) ? WIDTH'(sum - {1'b0, modulus})
                                        : sum[WIDTH-1:0];
      end
      if (add_en) begin
        sum <= {1'b0, acc} + {1'b0, addend};
      end
    end
  end

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime writer of the xpb reduction table: entry j = (j * base) mod modulus,
// streamed through a valid/ready write port, one entry every three cycles.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int WIDTH    = XPB_WIDTH,
  parameter int IDX_BITS = XPB_IDX_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    modulus,
  input  logic [WIDTH-1:0]    base,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data
);

  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;

  xpb_gen_state_t      state, state_nx;
  logic [WIDTH-1:0]    n_q, b_q, acc;
  logic [IDX_BITS-1:0] idx;
  logic                accept, xfer, bad_cfg;

  assign accept  = (state == ST_IDLE) && start;
  assign xfer    = (state == ST_EMIT) && wr_ready;
  assign bad_cfg = (b_q >= n_q);

  // NOTE: state_nx gets its default first so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_CHECK;
      ST_CHECK:  state_nx = bad_cfg ? ST_DONE : ST_EMIT;
      ST_EMIT:   if (xfer) state_nx = (idx == IDX_MAX) ? ST_DONE : ST_ADD;
      ST_ADD:    state_nx = ST_REDUCE;
      ST_REDUCE: state_nx = ST_EMIT;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      n_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      err   <= (state == ST_CHECK) && bad_cfg;
      wr_en <= (state_nx == ST_EMIT);
      if (accept) begin
        n_q <= modulus;
        b_q <= base;
        idx <= '0;
      end else if (state == ST_REDUCE) begin
        idx <= idx + 1'b1;
      end
    end
  end

  xpb_mod_step #(
    .WIDTH(WIDTH)
  ) u_mod_step (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .add_en   (state == ST_ADD),
    .reduce_en(state == ST_REDUCE),
    .addend   (b_q),
    .modulus  (n_q),
    .acc      (acc)
  );

  assign wr_addr = idx;
  assign wr_data = acc;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomized self-checking bench for xpb_table_gen against a (j*B) mod N model.
module tb_xpb_table_gen;

  localparam int W     = 16;
  localparam int IB    = 5;
  localparam int DEPTH = xpb_pkg::XPB_DEPTH;
  localparam int WW    = 1024;

  logic          clk = 1'b0;
  logic          reset, start, wr_ready;
  logic [W-1:0]  modulus, base, wr_data;
  logic          busy, done, err, wr_en;
  logic [IB-1:0] wr_addr;

  logic          start_w, busy_w, done_w, err_w, wr_en_w, wr_ready_w;
  logic [WW-1:0] modulus_w, base_w, wr_data_w;
  logic [IB-1:0] wr_addr_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xpb_table_gen #(.WIDTH(W), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .start(start), .modulus(modulus), .base(base),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  xpb_table_gen #(.WIDTH(WW), .IDX_BITS(IB)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .modulus(modulus_w), .base(base_w),
    .busy(busy_w), .done(done_w), .err(err_w), .wr_en(wr_en_w), .wr_ready(wr_ready_w),
    .wr_addr(wr_addr_w), .wr_data(wr_data_w)
  );

  // Results of the most recent run
  logic [W-1:0] got_data [DEPTH];
  int got_cyc [DEPTH];
  int n_writes, done_cyc, err_at_done, busy_first, busy_last;
  int stable_bad, drop_bad, wr_en_seen, timed_out;

  function automatic logic [W-1:0] model16(int j, logic [W-1:0] n, logic [W-1:0] b);
    longint unsigned p;
    p = longint'(j) * longint'(b);
    return W'(p % longint'(n));
  endfunction

  function automatic int bad_entries(logic [W-1:0] n, logic [W-1:0] b);
    int bad = 0;
    for (int j = 0; j < DEPTH; j++)
      if (got_data[j] !== model16(j, n, b)) bad++;
    return bad;
  endfunction

  function automatic int bad_timing(int stall_addr, int stall_len);
    int bad = 0;
    int exp_c;
    for (int j = 0; j < DEPTH; j++) begin
      exp_c = 2 + 3 * j + ((stall_addr >= 0 && j >= stall_addr) ? stall_len : 0);
      if (got_cyc[j] != exp_c) bad++;
    end
    return bad;
  endfunction

  // One full generation; cycle numbers are relative to the start cycle (0).
  task automatic run_gen(input logic [W-1:0] n, input logic [W-1:0] b, input int stall_addr,
                         input int stall_len, input bit rand_ready, input int ign_cyc);
    int t0, rel, stalled;
    bit holding, prev_en, prev_x, x;
    logic [IB-1:0] hold_addr;
    logic [W-1:0] hold_data;
    n_writes = 0; done_cyc = -1; err_at_done = 0; busy_first = -1; busy_last = -1;
    stable_bad = 0; drop_bad = 0; wr_en_seen = 0; timed_out = 0;
    for (int j = 0; j < DEPTH; j++) begin
      got_data[j] = 'x;
      got_cyc[j]  = -1;
    end
    stalled = 0; holding = 0; prev_en = 0; prev_x = 0;
    hold_addr = '0; hold_data = '0;
    @(posedge clk); #1;
    start = 1'b1; modulus = n; base = b; wr_ready = 1'b1; t0 = cyc;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      rel   = cyc - t0;
      start = (rel == ign_cyc);
      if (start) begin
        modulus = ~n;
        base    = b ^ 16'h5a5a;
      end
      if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
      else if (wr_en && int'(wr_addr) == stall_addr && stalled < stall_len) begin
        wr_ready = 1'b0;
        stalled++;
      end else wr_ready = 1'b1;
      x = wr_en && wr_ready;
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (wr_en) wr_en_seen++;
      if (prev_en && !prev_x && !wr_en) drop_bad++;
      if (wr_en && holding && (wr_addr !== hold_addr || wr_data !== hold_data)) stable_bad++;
      holding = wr_en && !wr_ready; hold_addr = wr_addr; hold_data = wr_data;
      if (x) begin
        n_writes++;
        got_data[wr_addr] = wr_data;
        got_cyc[wr_addr]  = rel;
      end
      prev_en = wr_en; prev_x = x;
      if (done) begin
        done_cyc    = rel;
        err_at_done = int'(err);
      end
      if (done_cyc >= 0 && rel > done_cyc) break;
    end
    wr_ready = 1'b1;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, wr_en});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      failures++;
      $display("FAIL reset_port: got addr %0h data %0h expected 0 0", wr_addr, wr_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_gen(16'hFFF1, 16'h1234, -1, 0, 1'b0, -1);
    checks++;
    if (timed_out != 0) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (n_writes != 32) begin failures++; $display("FAIL basic_writes: got %0d expected 32", n_writes); end
    checks++;
    if (bad_entries(16'hFFF1, 16'h1234) != 0) begin
      failures++; $display("FAIL basic_entries: got %0d bad expected 0", bad_entries(16'hFFF1, 16'h1234));
    end
    checks++;
    if (got_data[1] !== 16'h1234) begin failures++; $display("FAIL basic_addr1: got %h expected 1234", got_data[1]); end
    checks++;
    if (got_data[31] !== 16'h346A) begin failures++; $display("FAIL basic_addr31: got %h expected 346a", got_data[31]); end
    checks++;
    if (bad_timing(-1, 0) != 0) begin failures++; $display("FAIL basic_timing: got %0d late expected 0", bad_timing(-1, 0)); end
    checks++;
    if (done_cyc != 96) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 96", done_cyc); end
    checks++;
    if (err_at_done != 0) begin failures++; $display("FAIL basic_err: got %0d expected 0", err_at_done); end
    checks++;
    if (busy_first != 1 || busy_last != 96) begin
      failures++; $display("FAIL basic_busy: got %0d..%0d expected 1..96", busy_first, busy_last);
    end
  endtask

  task automatic test_wrap();
    run_gen(16'hFFF1, 16'hFFF0, -1, 0, 1'b0, -1);
    checks++;
    if (n_writes != 32 || bad_entries(16'hFFF1, 16'hFFF0) != 0) begin
      failures++; $display("FAIL wrap_entries: got %0d writes %0d bad expected 32 0",
                           n_writes, bad_entries(16'hFFF1, 16'hFFF0));
    end
    checks++;
    if (got_data[1] !== 16'hFFF0 || got_data[2] !== 16'hFFEF || got_data[31] !== 16'hFFD2) begin
      failures++; $display("FAIL wrap_points: got %h %h %h expected fff0 ffef ffd2",
                           got_data[1], got_data[2], got_data[31]);
    end
  endtask

  task automatic test_error();
    logic [W-1:0] nv [2];
    logic [W-1:0] bv [2];
    nv[0] = 16'hFFF1; bv[0] = 16'hFFF1;
    nv[1] = 16'h0000; bv[1] = W'($urandom);
    for (int c = 0; c < 2; c++) begin
      run_gen(nv[c], bv[c], -1, 0, 1'b0, -1);
      checks++;
      if (wr_en_seen != 0) begin failures++; $display("FAIL err%0d_wr_en: got %0d expected 0", c, wr_en_seen); end
      checks++;
      if (done_cyc != 2 || err_at_done != 1) begin
        failures++; $display("FAIL err%0d_pulse: got done %0d err %0d expected 2 1", c, done_cyc, err_at_done);
      end
      checks++;
      if (busy_first != 1 || busy_last != 2) begin
        failures++; $display("FAIL err%0d_busy: got %0d..%0d expected 1..2", c, busy_first, busy_last);
      end
    end
  endtask

  task automatic test_backpressure();
    run_gen(16'hFFF1, 16'h1234, 3, 5, 1'b0, -1);
    checks++;
    if (n_writes != 32 || bad_entries(16'hFFF1, 16'h1234) != 0) begin
      failures++; $display("FAIL bp_entries: got %0d writes expected 32 all matching", n_writes);
    end
    checks++;
    if (got_data[3] !== 16'h369C) begin failures++; $display("FAIL bp_addr3: got %h expected 369c", got_data[3]); end
    checks++;
    if (stable_bad != 0 || drop_bad != 0) begin
      failures++; $display("FAIL bp_stable: got %0d unstable %0d drops expected 0 0", stable_bad, drop_bad);
    end
    checks++;
    if (bad_timing(3, 5) != 0) begin failures++; $display("FAIL bp_timing: got %0d off expected 0", bad_timing(3, 5)); end
    checks++;
    if (done_cyc != 101) begin failures++; $display("FAIL bp_done_cycle: got %0d expected 101", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int found = 0;
    int late_en = 0;
    @(posedge clk); #1;
    start = 1'b1; modulus = 16'hFFF1; base = 16'h1234; wr_ready = 1'b1;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wr_en && wr_addr == 5'd10) found = 1;
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL rst_mid_reach: got no addr 10 expected addr 10"); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wr_en, busy, done} !== 3'b0 || wr_addr !== '0 || wr_data !== '0) begin
      failures++; $display("FAIL rst_mid_clear: got en %b busy %b done %b addr %0h expected all 0",
                           wr_en, busy, done, wr_addr);
    end
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wr_en || busy) late_en++;
    end
    checks++;
    if (late_en != 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", late_en); end
    run_gen(16'hFFF1, 16'h1234, -1, 0, 1'b0, -1);
    checks++;
    if (n_writes != 32 || bad_entries(16'hFFF1, 16'h1234) != 0 || got_cyc[0] != 2) begin
      failures++; $display("FAIL rst_mid_regen: got %0d writes first at %0d expected 32 at 2", n_writes, got_cyc[0]);
    end
  endtask

  task automatic test_ignored_start();
    run_gen(16'hFFF1, 16'h0ABC, -1, 0, 1'b0, 20);
    checks++;
    if (n_writes != 32 || bad_entries(16'hFFF1, 16'h0ABC) != 0 || done_cyc != 96) begin
      failures++; $display("FAIL ign_start: got %0d writes done %0d expected 32 done 96", n_writes, done_cyc);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n, b;
    for (int r = 0; r < 6; r++) begin
      n = W'($urandom_range(1, 65535));
      b = W'($urandom_range(0, int'(n) - 1));
      run_gen(n, b, -1, 0, 1'b1, -1);
      checks++;
      if (timed_out != 0 || n_writes != 32 || bad_entries(n, b) != 0 || err_at_done != 0) begin
        failures++; $display("FAIL rand%0d n=%h b=%h: got %0d writes %0d bad err %0d expected 32 0 0",
                             r, n, b, n_writes, bad_entries(n, b), err_at_done);
      end
      checks++;
      if (stable_bad != 0 || drop_bad != 0) begin
        failures++; $display("FAIL rand%0d_hs: got %0d unstable %0d drops expected 0 0", r, stable_bad, drop_bad);
      end
    end
  endtask

  task automatic test_full_width();
    logic [2*WW-1:0] n_ext, b_ext, e_ext;
    logic [WW-1:0] nw, bw;
    logic [WW-1:0] got_w [DEPTH];
    int t0, rel, nwr, bad, dcyc, derr;
    for (int i = 0; i < WW / 32; i++) nw[i*32 +: 32] = $urandom;
    nw[WW-1] = 1'b1;
    nw[0]    = 1'b1;
    n_ext = {{WW{1'b0}}, nw};
    b_ext = ((2*WW)'(1) << 1030) % n_ext;
    bw    = b_ext[WW-1:0];
    nwr = 0; dcyc = -1; derr = 0;
    for (int j = 0; j < DEPTH; j++) got_w[j] = 'x;
    @(posedge clk); #1;
    start_w = 1'b1; modulus_w = nw; base_w = bw; wr_ready_w = 1'b1; t0 = cyc;
    for (int k = 0; k < 200 && dcyc < 0; k++) begin
      @(posedge clk); #1;
      start_w = 1'b0;
      rel = cyc - t0;
      if (wr_en_w && wr_ready_w) begin
        nwr++;
        got_w[wr_addr_w] = wr_data_w;
      end
      if (done_w) begin
        dcyc = rel;
        derr = int'(err_w);
      end
    end
    bad = 0;
    for (int j = 0; j < DEPTH; j++) begin
      e_ext = ((2*WW)'(j) * b_ext) % n_ext;
      if (got_w[j] !== e_ext[WW-1:0]) begin
        bad++;
        if (bad == 1) $display("FAIL wide_entry%0d: got low %h expected low %h",
                               j, got_w[j][63:0], e_ext[63:0]);
      end
    end
    checks++;
    if (bad != 0 || nwr != 32) begin failures++; $display("FAIL wide_table: got %0d bad %0d writes expected 0 32", bad, nwr); end
    checks++;
    if (dcyc != 96 || derr != 0) begin failures++; $display("FAIL wide_done: got %0d err %0d expected 96 0", dcyc, derr); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_ready = 1'b1; modulus = '0; base = '0;
    start_w = 1'b0; wr_ready_w = 1'b1; modulus_w = '0; base_w = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_random();
    test_full_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
